// File: rtl/row_dot_pkg.sv
// rtl/row_dot_pkg.sv - shared FSM encodings and width derivations for the row dot-product engine
package row_dot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Sum of 2**addr_width full products cannot overflow this width.
    function automatic int acc_width(input int data_width, input int addr_width);
        return 2 * data_width + addr_width;
    endfunction

endpackage

// File: rtl/dot_mac_slice.sv
// rtl/dot_mac_slice.sv - registered signed multiply feeding a wide accumulator
module dot_mac_slice
    import row_dot_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    localparam int PROD_W    = prod_width(DATA_WIDTH),
    localparam int ACC_W     = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mul_en,
    input  logic              add_en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [PROD_W-1:0] prod_q,
    output logic [ACC_W-1:0]  acc_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (clear) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (mul_en) begin
                prod_q <= PROD_W'($signed(a)) * PROD_W'($signed(b));
            end
            // The accumulator consumes the product registered one cycle earlier.
            if (add_en) begin
                acc_q <= acc_q + ACC_W'($signed(prod_q));
            end
        end
    end

endmodule

// File: rtl/row_dot_engine.sv
// rtl/row_dot_engine.sv - drains a row buffer into a biased fixed-point dot product (DOT_SAT_EN: saturating result)
module row_dot_engine
    import row_dot_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_done,
    output logic                  row_rd_en,
    output logic [ADDR_WIDTH-1:0] row_rd_addr,
    input  logic [DATA_WIDTH-1:0] row_dout,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  busy
);

    localparam int PROD_W = prod_width(DATA_WIDTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam int SUM_W  = ACC_W + 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [PROD_W-1:0]       prod_q;
    logic [ACC_W-1:0]        acc_q;
    logic signed [SUM_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   y_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (row_done) state_d = ST_READ;
            ST_READ:  if (&addr_q) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   if (y_valid && y_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address wraps back to zero on the last read, so it idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (state_q == ST_READ) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
        end else begin
            addr_q <= '0;
        end
    end

    assign row_rd_en   = (state_q == ST_READ);
    assign row_rd_addr = addr_q;
    assign w_addr      = addr_q;
    assign busy        = (state_q != ST_IDLE);

    dot_mac_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == ST_IDLE),
        .mul_en (state_q == ST_READ),
        .add_en ((state_q == ST_READ) || (state_q == ST_DRAIN)),
        .a      (row_dout),
        .b      (w_data),
        .prod_q (prod_q),
        .acc_q  (acc_q)
    );

    // The final product is folded in here rather than waiting a cycle for acc_q.
    assign sum = SUM_W'($signed(acc_q)) + SUM_W'($signed(prod_q))
               + (SUM_W'($signed(bias)) <<< FRAC_BITS);

`ifdef DOT_SAT_EN
    logic signed [SUM_W-1:0] shifted;

    always_comb begin
        shifted = sum >>> FRAC_BITS;
        y_next  = shifted[DATA_WIDTH-1:0];
        if (shifted[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){shifted[SUM_W-1]}}) begin
            y_next = shifted[SUM_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        y_next = DATA_WIDTH'(sum >>> FRAC_BITS);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data  <= '0;
            y_valid <= 1'b0;
        end else begin
            if (state_q == ST_DRAIN) begin
                y_data <= y_next;
            end
            if (state_q == ST_OUT) begin
                if (!y_valid) begin
                    y_valid <= 1'b1;
                end else if (y_ready) begin
                    y_valid <= 1'b0;
                end
            end
        end
    end

endmodule
